controlador_vendas: RTL and testbench

- Sequencing FSM for the vending-machine datapath.
- Accumulates inserted coin units, latches the product selection, and drives the price comparator (valorMoedas, valorProduto, enable) for exactly one evaluation cycle.
- Acts on the comparator verdict (liberarProduto / devolverMoedas) by issuing a timed dispense or refund pulse, then clears for the next customer.
- Sits between the front-panel inputs and the comparator/actuator outputs.

---
 rtl/controlador_vendas.sv | 195 +++++++++++++++++++
 tb/tb_controlador_vendas.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_vendas.sv
// controlador_vendas: sequencing FSM for the vending-machine datapath.
// Collects coin units, latches the product code, runs the external price
// comparator for one cycle and turns its verdict into a timed dispense or
// refund pulse. Every output comes straight from a flop.
//
// Input strobe semantics: moedaValida, confirmar and cancelar are one-cycle
// strobes with no back-pressure. Each is consumed on the rising edge where it
// is high. A coin that cannot be taken (bad code, overflow, busy, or beaten by
// cancelar/confirmar) is refused, and moedaRejeitada is raised for the
// following cycle.
module controlador_vendas #(
    parameter int TEMPO_LIMITE  = 1000,
    parameter int PULSO_SAIDA   = 4,
    parameter int LARGURA_TEMPO = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       moedaValida,
    input  logic [1:0] moedaValor,
    input  logic [2:0] produtoSel,
    input  logic       confirmar,
    input  logic       cancelar,
    input  logic       liberarProduto,
    input  logic       devolverMoedas,
    output logic [3:0] valorMoedas,
    output logic [2:0] valorProduto,
    output logic       enable,
    output logic       dispensar,
    output logic       devolver,
    output logic [3:0] valorDevolvido,
    output logic       moedaRejeitada,
    output logic       ocupado,
    output logic [2:0] estadoAtual
);

    localparam int LARGURA_PULSO = (PULSO_SAIDA > 1) ? $clog2(PULSO_SAIDA) : 1;
    localparam logic [LARGURA_TEMPO-1:0] TEMPO_FIM = LARGURA_TEMPO'(TEMPO_LIMITE - 1);
    localparam logic [LARGURA_PULSO-1:0] PULSO_FIM = LARGURA_PULSO'(PULSO_SAIDA - 1);

    typedef enum logic [2:0] {
        OCIOSO     = 3'd0,
        ACUMULANDO = 3'd1,
        COMPARAR   = 3'd2,
        LIBERAR    = 3'd3,
        DEVOLVER   = 3'd4
    } estado_t;

    estado_t                  estado, estadoProx;
    logic [LARGURA_TEMPO-1:0] tempo, tempoProx;
    logic [LARGURA_PULSO-1:0] pulso, pulsoProx;
    logic [3:0]               moedasProx;
    logic [2:0]               produtoProx;
    logic [3:0]               devolvidoProx;
    logic                     rejeitadaProx;

    // Coin codes 01 and 10 carry their own unit value; 00 and 11 are invalid.
    logic       codigoOk;
    logic [4:0] somaMoedas;
    logic       moedaCabe;

    assign codigoOk    = (moedaValor == 2'b01) || (moedaValor == 2'b10);
    assign somaMoedas  = {1'b0, valorMoedas} + {3'b000, moedaValor};
    assign moedaCabe   = codigoOk && !somaMoedas[4];
    assign estadoAtual = estado;

    // Next-state and next-register values; outputs are registered from these.
    always_comb begin
        estadoProx    = estado;
        tempoProx     = tempo;
        pulsoProx     = pulso;
        moedasProx    = valorMoedas;
        produtoProx   = valorProduto;
        devolvidoProx = valorDevolvido;
        rejeitadaProx = 1'b0;

        case (estado)
            OCIOSO: begin
                tempoProx = '0;
                pulsoProx = '0;
                if (moedaValida) begin
                    if (moedaCabe) begin
                        moedasProx = somaMoedas[3:0];
                        estadoProx = ACUMULANDO;
                    end else begin
                        rejeitadaProx = 1'b1;
                    end
                end
            end

            ACUMULANDO: begin
                if (cancelar) begin
                    rejeitadaProx = moedaValida;
                    devolvidoProx = valorMoedas;
                    tempoProx     = '0;
                    estadoProx    = DEVOLVER;
                end else if (confirmar) begin
                    rejeitadaProx = moedaValida;
                    produtoProx   = produtoSel;
                    tempoProx     = '0;
                    estadoProx    = COMPARAR;
                end else if (moedaValida && moedaCabe) begin
                    moedasProx = somaMoedas[3:0];
                    tempoProx  = '0;
                end else begin
                    // A refused coin is not customer progress, so the idle timer keeps running.
                    rejeitadaProx = moedaValida;
                    if (tempo == TEMPO_FIM) begin
                        devolvidoProx = valorMoedas;
                        tempoProx     = '0;
                        estadoProx    = DEVOLVER;
                    end else begin
                        tempoProx = tempo + LARGURA_TEMPO'(1);
                    end
                end
            end

            COMPARAR: begin
                rejeitadaProx = moedaValida;
                pulsoProx     = '0;
                // A contradictory verdict (both high) is treated as a refund.
                if (liberarProduto && !devolverMoedas) begin
                    estadoProx = LIBERAR;
                end else begin
                    devolvidoProx = valorMoedas;
                    estadoProx    = DEVOLVER;
                end
            end

            LIBERAR: begin
                rejeitadaProx = moedaValida;
                if (pulso == PULSO_FIM) begin
                    pulsoProx   = '0;
                    moedasProx  = '0;
                    produtoProx = '0;
                    estadoProx  = OCIOSO;
                end else begin
                    pulsoProx = pulso + LARGURA_PULSO'(1);
                end
            end

            DEVOLVER: begin
                rejeitadaProx = moedaValida;
                if (pulso == PULSO_FIM) begin
                    pulsoProx     = '0;
                    moedasProx    = '0;
                    produtoProx   = '0;
                    devolvidoProx = '0;
                    estadoProx    = OCIOSO;
                end else begin
                    pulsoProx = pulso + LARGURA_PULSO'(1);
                end
            end

            default: begin
                estadoProx    = OCIOSO;
                tempoProx     = '0;
                pulsoProx     = '0;
                moedasProx    = '0;
                produtoProx   = '0;
                devolvidoProx = '0;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any pulse in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado         <= OCIOSO;
            tempo          <= '0;
            pulso          <= '0;
            valorMoedas    <= '0;
            valorProduto   <= '0;
            valorDevolvido <= '0;
            moedaRejeitada <= 1'b0;
            enable         <= 1'b0;
            dispensar      <= 1'b0;
            devolver       <= 1'b0;
            ocupado        <= 1'b0;
        end else begin
            estado         <= estadoProx;
            tempo          <= tempoProx;
            pulso          <= pulsoProx;
            valorMoedas    <= moedasProx;
            valorProduto   <= produtoProx;
            valorDevolvido <= devolvidoProx;
            moedaRejeitada <= rejeitadaProx;
            enable         <= (estadoProx == COMPARAR);
            dispensar      <= (estadoProx == LIBERAR);
            devolver       <= (estadoProx == DEVOLVER);
            ocupado        <= (estadoProx == COMPARAR) || (estadoProx == LIBERAR) ||
                              (estadoProx == DEVOLVER);
        end
    end

endmodule

// File: tb/tb_controlador_vendas.sv
// Testbench for controlador_vendas: directed scenarios plus randomized
// purchases scored against a transaction-level model of the vending rules.
module tb_controlador_vendas;

    localparam int TEMPO_LIMITE = 8;
    localparam int PULSO_SAIDA  = 4;

    logic       clk;
    logic       rst_n;
    logic       moedaValida;
    logic [1:0] moedaValor;
    logic [2:0] produtoSel;
    logic       confirmar;
    logic       cancelar;
    logic       liberarProduto;
    logic       devolverMoedas;
    logic [3:0] valorMoedas;
    logic [2:0] valorProduto;
    logic       enable;
    logic       dispensar;
    logic       devolver;
    logic [3:0] valorDevolvido;
    logic       moedaRejeitada;
    logic       ocupado;
    logic [2:0] estadoAtual;

    int total = 0;
    int bad   = 0;

    // Expected outcome per purchase: {is_refund, amount}.
    logic [4:0] exp_q[$];

    // Price list of the comparator, in coin units, indexed by product code.
    int price_tbl[8] = '{0, 2, 4, 5, 6, 7, 8, 0};

    controlador_vendas #(
        .TEMPO_LIMITE  (TEMPO_LIMITE),
        .PULSO_SAIDA   (PULSO_SAIDA),
        .LARGURA_TEMPO (10)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .moedaValida    (moedaValida),
        .moedaValor     (moedaValor),
        .produtoSel     (produtoSel),
        .confirmar      (confirmar),
        .cancelar       (cancelar),
        .liberarProduto (liberarProduto),
        .devolverMoedas (devolverMoedas),
        .valorMoedas    (valorMoedas),
        .valorProduto   (valorProduto),
        .enable         (enable),
        .dispensar      (dispensar),
        .devolver       (devolver),
        .valorDevolvido (valorDevolvido),
        .moedaRejeitada (moedaRejeitada),
        .ocupado        (ocupado),
        .estadoAtual    (estadoAtual)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External comparator: combinational exact-payment check.
    assign liberarProduto = enable && (int'(valorMoedas) == price_tbl[valorProduto]);
    assign devolverMoedas = enable && !liberarProduto;

    // Driver tasks: inputs change on the falling edge, outputs observed there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic put_coin(input logic [1:0] v);
        moedaValida = 1'b1;
        moedaValor  = v;
        step();
        moedaValida = 1'b0;
        moedaValor  = 2'b00;
    endtask

    task automatic press_confirm(input logic [2:0] p);
        produtoSel = p;
        confirmar  = 1'b1;
        step();
        confirmar  = 1'b0;
    endtask

    task automatic press_cancel();
        cancelar = 1'b1;
        step();
        cancelar = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        moedaValida = 1'b1;
        moedaValor  = 2'b11;
        idle(2);
        total++; if (valorMoedas !== 4'd0) begin bad++; $display("FAIL rst_moedas got=%0d exp=0", valorMoedas); end
        total++; if (valorProduto !== 3'd0) begin bad++; $display("FAIL rst_produto got=%0d exp=0", valorProduto); end
        total++; if (enable !== 1'b0) begin bad++; $display("FAIL rst_enable got=%b exp=0", enable); end
        total++; if (dispensar !== 1'b0) begin bad++; $display("FAIL rst_dispensar got=%b exp=0", dispensar); end
        total++; if (devolver !== 1'b0) begin bad++; $display("FAIL rst_devolver got=%b exp=0", devolver); end
        total++; if (valorDevolvido !== 4'd0) begin bad++; $display("FAIL rst_devolvido got=%0d exp=0", valorDevolvido); end
        total++; if (moedaRejeitada !== 1'b0) begin bad++; $display("FAIL rst_rejeitada got=%b exp=0", moedaRejeitada); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL rst_ocupado got=%b exp=0", ocupado); end
        moedaValida = 1'b0;
        moedaValor  = 2'b00;
        rst_n       = 1'b1;
        step();
    endtask

    task automatic test_purchase_ok();
        put_coin(2'b10);
        total++; if (valorMoedas !== 4'd2) begin bad++; $display("FAIL ok_moedas1 got=%0d exp=2", valorMoedas); end
        put_coin(2'b10);
        total++; if (valorMoedas !== 4'd4) begin bad++; $display("FAIL ok_moedas2 got=%0d exp=4", valorMoedas); end
        press_confirm(3'd2);
        total++; if (enable !== 1'b1) begin bad++; $display("FAIL ok_enable got=%b exp=1", enable); end
        total++; if (ocupado !== 1'b1) begin bad++; $display("FAIL ok_ocupado got=%b exp=1", ocupado); end
        total++; if (valorProduto !== 3'd2) begin bad++; $display("FAIL ok_produto got=%0d exp=2", valorProduto); end
        step();
        total++; if (enable !== 1'b0) begin bad++; $display("FAIL ok_enable_once got=%b exp=0", enable); end
        for (int i = 0; i < PULSO_SAIDA; i++) begin
            total++; if (dispensar !== 1'b1 || devolver !== 1'b0) begin bad++; $display("FAIL ok_pulse cyc=%0d disp=%b dev=%b exp=1/0", i, dispensar, devolver); end
            step();
        end
        total++; if (dispensar !== 1'b0) begin bad++; $display("FAIL ok_pulse_end got=%b exp=0", dispensar); end
        total++; if (valorMoedas !== 4'd0) begin bad++; $display("FAIL ok_clear_moedas got=%0d exp=0", valorMoedas); end
        total++; if (valorProduto !== 3'd0) begin bad++; $display("FAIL ok_clear_produto got=%0d exp=0", valorProduto); end
        total++; if (ocupado !== 1'b0) begin bad++; $display("FAIL ok_idle got=%b exp=0", ocupado); end
    endtask

    task automatic test_refund_mismatch();
        put_coin(2'b10);
        put_coin(2'b10);
        put_coin(2'b01);
        total++; if (valorMoedas !== 4'd5) begin bad++; $display("FAIL mis_moedas got=%0d exp=5", valorMoedas); end
        press_confirm(3'd1);
        total++; if (enable !== 1'b1) begin bad++; $display("FAIL mis_enable got=%b exp=1", enable); end
        step();
        for (int i = 0; i < PULSO_SAIDA; i++) begin
            total++; if (devolver !== 1'b1 || dispensar !== 1'b0) begin bad++; $display("FAIL mis_pulse cyc=%0d dev=%b disp=%b exp=1/0", i, devolver, dispensar); end
            total++; if (valorDevolvido !== 4'd5) begin bad++; $display("FAIL mis_devolvido cyc=%0d got=%0d exp=5", i, valorDevolvido); end
            step();
        end
        total++; if (devolver !== 1'b0) begin bad++; $display("FAIL mis_pulse_end got=%b exp=0", devolver); end
        total++; if (valorDevolvido !== 4'd0) begin bad++; $display("FAIL mis_devolvido_clr got=%0d exp=0", valorDevolvido); end
        total++; if (valorMoedas !== 4'd0) begin bad++; $display("FAIL mis_moedas_clr got=%0d exp=0", valorMoedas); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 7; i++) put_coin(2'b10);
        total++; if (valorMoedas !== 4'd14) begin bad++; $display("FAIL ovf_14 got=%0d exp=14", valorMoedas); end
        put_coin(2'b10);
        total++; if (moedaRejeitada !== 1'b1) begin bad++; $display("FAIL ovf_rej got=%b exp=1", moedaRejeitada); end
        total++; if (valorMoedas !== 4'd14) begin bad++; $display("FAIL ovf_hold got=%0d exp=14", valorMoedas); end
        step();
        total++; if (moedaRejeitada !== 1'b0) begin bad++; $display("FAIL ovf_rej_once got=%b exp=0", moedaRejeitada); end
        put_coin(2'b01);
        total++; if (valorMoedas !== 4'd15) begin bad++; $display("FAIL ovf_15 got=%0d exp=15", valorMoedas); end
        total++; if (moedaRejeitada !== 1'b0) begin bad++; $display("FAIL ovf_15_rej got=%b exp=0", moedaRejeitada); end
        put_coin(2'b11);
        total++; if (moedaRejeitada !== 1'b1 || valorMoedas !== 4'd15) begin bad++; $display("FAIL ovf_code11 rej=%b moedas=%0d exp=1/15", moedaRejeitada, valorMoedas); end
        put_coin(2'b01);
        total++; if (moedaRejeitada !== 1'b1 || valorMoedas !== 4'd15) begin bad++; $display("FAIL ovf_full rej=%b moedas=%0d exp=1/15", moedaRejeitada, valorMoedas); end
        put_coin(2'b00);
        total++; if (moedaRejeitada !== 1'b1 || valorMoedas !== 4'd15) begin bad++; $display("FAIL ovf_code00 rej=%b moedas=%0d exp=1/15", moedaRejeitada, valorMoedas); end
        press_cancel();
        total++; if (devolver !== 1'b1 || valorDevolvido !== 4'd15) begin bad++; $display("FAIL ovf_cancel dev=%b val=%0d exp=1/15", devolver, valorDevolvido); end
        idle(PULSO_SAIDA + 2);
    endtask

    task automatic test_timeout();
        int n;
        put_coin(2'b01);
        n = 0;
        while (devolver !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        total++; if (n != TEMPO_LIMITE) begin bad++; $display("FAIL to_cycles got=%0d exp=%0d", n, TEMPO_LIMITE); end
        total++; if (valorDevolvido !== 4'd1) begin bad++; $display("FAIL to_devolvido got=%0d exp=1", valorDevolvido); end
        idle(PULSO_SAIDA + 2);
        total++; if (ocupado !== 1'b0 || valorMoedas !== 4'd0) begin bad++; $display("FAIL to_idle ocup=%b moedas=%0d exp=0/0", ocupado, valorMoedas); end
        // cancelar and confirmar together: cancel wins
        put_coin(2'b10);
        produtoSel = 3'd2;
        cancelar   = 1'b1;
        confirmar  = 1'b1;
        step();
        cancelar   = 1'b0;
        confirmar  = 1'b0;
        total++; if (enable !== 1'b0) begin bad++; $display("FAIL both_enable got=%b exp=0", enable); end
        total++; if (devolver !== 1'b1 || valorDevolvido !== 4'd2) begin bad++; $display("FAIL both_refund dev=%b val=%0d exp=1/2", devolver, valorDevolvido); end
        idle(PULSO_SAIDA + 2);
    endtask

    task automatic test_busy_coin();
        put_coin(2'b10);
        put_coin(2'b10);
        press_confirm(3'd2);
        step();
        put_coin(2'b10);
        total++; if (moedaRejeitada !== 1'b1) begin bad++; $display("FAIL busy_rej got=%b exp=1", moedaRejeitada); end
        total++; if (valorMoedas !== 4'd4) begin bad++; $display("FAIL busy_moedas got=%0d exp=4", valorMoedas); end
        total++; if (dispensar !== 1'b1) begin bad++; $display("FAIL busy_disp got=%b exp=1", dispensar); end
        idle(PULSO_SAIDA);
        total++; if (dispensar !== 1'b0 || valorMoedas !== 4'd0) begin bad++; $display("FAIL busy_end disp=%b moedas=%0d exp=0/0", dispensar, valorMoedas); end
        press_confirm(3'd3);
        total++; if (enable !== 1'b0 || ocupado !== 1'b0) begin bad++; $display("FAIL idle_confirm en=%b ocup=%b exp=0/0", enable, ocupado); end
        step();
        total++; if (enable !== 1'b0) begin bad++; $display("FAIL idle_confirm2 got=%b exp=0", enable); end
    endtask

    task automatic test_reset_mid();
        put_coin(2'b10);
        put_coin(2'b10);
        press_confirm(3'd2);
        step();
        step();
        total++; if (dispensar !== 1'b1) begin bad++; $display("FAIL rm_disp2 got=%b exp=1", dispensar); end
        rst_n = 1'b0;
        step();
        total++; if (dispensar !== 1'b0 || devolver !== 1'b0 || enable !== 1'b0) begin bad++; $display("FAIL rm_pulses disp=%b dev=%b en=%b exp=0", dispensar, devolver, enable); end
        total++; if (valorMoedas !== 4'd0 || valorProduto !== 3'd0 || valorDevolvido !== 4'd0) begin bad++; $display("FAIL rm_values moedas=%0d prod=%0d dev=%0d exp=0", valorMoedas, valorProduto, valorDevolvido); end
        total++; if (ocupado !== 1'b0 || moedaRejeitada !== 1'b0) begin bad++; $display("FAIL rm_flags ocup=%b rej=%b exp=0", ocupado, moedaRejeitada); end
        rst_n = 1'b1;
        step();
        total++; if (dispensar !== 1'b0 || devolver !== 1'b0) begin bad++; $display("FAIL rm_no_resume disp=%b dev=%b exp=0", dispensar, devolver); end
        put_coin(2'b01);
        put_coin(2'b01);
        press_confirm(3'd1);
        total++; if (enable !== 1'b1) begin bad++; $display("FAIL rm_enable got=%b exp=1", enable); end
        step();
        total++; if (dispensar !== 1'b1) begin bad++; $display("FAIL rm_buy got=%b exp=1", dispensar); end
        idle(PULSO_SAIDA);
        total++; if (dispensar !== 1'b0 || ocupado !== 1'b0) begin bad++; $display("FAIL rm_buy_end disp=%b ocup=%b exp=0", dispensar, ocupado); end
    endtask

    task automatic test_back_to_back_random();
        int prod, price, credit, target, c;
        logic [4:0] e;
        for (int t = 0; t < 24; t++) begin
            prod   = $urandom_range(1, 6);
            price  = price_tbl[prod];
            credit = 0;
            target = ($urandom_range(0, 1) == 1) ? price : $urandom_range(1, 12);
            while (credit < target) begin
                if ($urandom_range(0, 3) == 0) begin
                    put_coin(($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00);
                    total++; if (moedaRejeitada !== 1'b1 || int'(valorMoedas) != credit) begin bad++; $display("FAIL rnd_badcode t=%0d rej=%b moedas=%0d exp=1/%0d", t, moedaRejeitada, valorMoedas, credit); end
                end
                c = (target - credit >= 2 && $urandom_range(0, 1) == 1) ? 2 : 1;
                put_coin(c[1:0]);
                credit += c;
                total++; if (int'(valorMoedas) != credit || moedaRejeitada !== 1'b0) begin bad++; $display("FAIL rnd_coin t=%0d moedas=%0d rej=%b exp=%0d/0", t, valorMoedas, moedaRejeitada, credit); end
                idle($urandom_range(0, 3));
            end
            exp_q.push_back({(credit != price), 4'(credit)});
            press_confirm(prod[2:0]);
            total++; if (enable !== 1'b1 || int'(valorProduto) != prod) begin bad++; $display("FAIL rnd_enable t=%0d en=%b prod=%0d exp=1/%0d", t, enable, valorProduto, prod); end
            step();
            e = exp_q.pop_front();
            if (e[4]) begin
                total++; if (devolver !== 1'b1 || dispensar !== 1'b0 || valorDevolvido !== e[3:0]) begin bad++; $display("FAIL rnd_refund t=%0d dev=%b disp=%b val=%0d exp=1/0/%0d", t, devolver, dispensar, valorDevolvido, e[3:0]); end
            end else begin
                total++; if (dispensar !== 1'b1 || devolver !== 1'b0) begin bad++; $display("FAIL rnd_dispense t=%0d disp=%b dev=%b exp=1/0", t, dispensar, devolver); end
            end
            idle(PULSO_SAIDA);
            total++; if (ocupado !== 1'b0 || valorMoedas !== 4'd0 || dispensar !== 1'b0 || devolver !== 1'b0) begin bad++; $display("FAIL rnd_done t=%0d ocup=%b moedas=%0d disp=%b dev=%b exp=0", t, ocupado, valorMoedas, dispensar, devolver); end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        moedaValida = 1'b0;
        moedaValor  = 2'b00;
        produtoSel  = 3'd0;
        confirmar   = 1'b0;
        cancelar    = 1'b0;
        test_reset();
        test_purchase_ok();
        test_refund_mismatch();
        test_overflow();
        test_timeout();
        test_busy_coin();
        test_reset_mid();
        test_back_to_back_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
